// File: rtl/i2c_target_if.sv
// Bus bundle for the I2C target: raw pin levels, open-drain SDA enable and the
// host-side receive FIFO / transmit byte handshake.
interface i2c_target_if #(
    parameter int W = 8,
    parameter int M = 4
);
    logic         scl_in;
    logic         sda_in;
    logic         sda_oe;
    logic [W-1:0] rx_data;
    logic         rx_rd;
    logic         rx_empty;
    logic         rx_full;
    logic         rx_overflow;
    logic         clear_overflow;
    logic [M:0]   rx_count;
    logic [W-1:0] tx_data;
    logic         tx_req;
    logic         busy;

    modport slave (
        input  scl_in, sda_in, rx_rd, clear_overflow, tx_data,
        output sda_oe, rx_data, rx_empty, rx_full, rx_overflow, rx_count, tx_req, busy
    );

    modport master (
        output scl_in, sda_in, rx_rd, clear_overflow, tx_data,
        input  sda_oe, rx_data, rx_empty, rx_full, rx_overflow, rx_count, tx_req, busy
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target endpoint: START/STOP detection, 7-bit address match, write bytes
// into a first-word fall-through RX FIFO, read bytes served from tx_data.
module i2c_target #(
    parameter logic [6:0] OWN_ADDR = 7'h50,
    parameter int         W        = 8,
    parameter int         M        = 4
) (
    input logic         clk,
    input logic         reset,
    i2c_target_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    localparam int             DEPTH  = 1 << M;
    localparam logic [M:0]     C_FULL = (M+1)'(DEPTH);

    state_t       r_state;
    state_t       w_nextState;

    logic [1:0]   r_sclSync;
    logic [1:0]   r_sdaSync;
    logic         r_sclPrev;
    logic         r_sdaPrev;
    logic         w_scl;
    logic         w_sda;
    logic         w_sclRise;
    logic         w_sclFall;
    logic         w_start;
    logic         w_stop;

    logic [2:0]   r_bitCnt;
    logic         r_byteDone;
    logic [W-1:0] r_shift;
    logic [W-1:0] r_txShift;
    logic         r_sdaOe;
    logic         r_busy;
    logic         r_overflow;
    logic         w_addrMatch;
    logic         w_shiftState;

    logic         w_sdaOeNext;
    logic         w_busyNext;
    logic         w_txLoad;
    logic         w_push;
    logic         w_setOvf;

    logic [W-1:0] r_mem [DEPTH];
    logic [M:0]   r_wrPtr;
    logic [M:0]   r_rdPtr;
    logic [M:0]   w_count;
    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_canPush;

    // Synchronizers idle high so a reset never fakes a START or SCL edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclSync <= 2'b11;
            r_sdaSync <= 2'b11;
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclSync <= {r_sclSync[0], bus.scl_in};
            r_sdaSync <= {r_sdaSync[0], bus.sda_in};
            r_sclPrev <= r_sclSync[1];
            r_sdaPrev <= r_sdaSync[1];
        end
    end

    assign w_scl        = r_sclSync[1];
    assign w_sda        = r_sdaSync[1];
    assign w_sclRise    = w_scl & ~r_sclPrev;
    assign w_sclFall    = ~w_scl & r_sclPrev;
    assign w_start      = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
    assign w_stop       = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;
    assign w_addrMatch  = (r_shift[W-1:1] == OWN_ADDR);
    assign w_shiftState = (r_state == S_ADDR) || (r_state == S_WR_DATA) || (r_state == S_RD_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_start) begin
            w_nextState = S_ADDR;
        end else if (w_stop) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:     if (w_sclFall && r_byteDone) w_nextState = w_addrMatch ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK: if (w_sclFall) w_nextState = r_shift[0] ? S_RD_DATA : S_WR_DATA;
                S_WR_DATA:  if (w_sclFall && r_byteDone) w_nextState = S_WR_ACK;
                S_WR_ACK:   if (w_sclFall) w_nextState = S_WR_DATA;
                S_RD_DATA:  if (w_sclFall && r_byteDone) w_nextState = S_RD_ACK;
                S_RD_ACK: begin
                    if (w_sclRise && w_sda) begin
                        w_nextState = S_IGNORE;
                    end else if (w_sclFall) begin
                        w_nextState = S_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // The first SCL fall after START precedes any bit, so byteDone gates completion.
    always_comb begin
        w_sdaOeNext = r_sdaOe;
        w_txLoad    = 1'b0;
        w_push      = 1'b0;
        w_setOvf    = 1'b0;
        if (w_start || w_stop) begin
            w_sdaOeNext = 1'b0;
        end else if (w_sclFall) begin
            case (r_state)
                S_ADDR: begin
                    if (r_byteDone) w_sdaOeNext = w_addrMatch;
                end
                S_ADDR_ACK: begin
                    if (r_shift[0]) begin
                        w_txLoad    = 1'b1;
                        w_sdaOeNext = ~bus.tx_data[W-1];
                    end else begin
                        w_sdaOeNext = 1'b0;
                    end
                end
                S_WR_DATA: begin
                    if (r_byteDone) begin
                        if (w_canPush) begin
                            w_push      = 1'b1;
                            w_sdaOeNext = 1'b1;
                        end else begin
                            w_setOvf    = 1'b1;
                            w_sdaOeNext = 1'b0;
                        end
                    end
                end
                S_RD_DATA:  w_sdaOeNext = r_byteDone ? 1'b0 : ~r_txShift[W-1];
                S_RD_ACK: begin
                    w_txLoad    = 1'b1;
                    w_sdaOeNext = ~bus.tx_data[W-1];
                end
                default:    w_sdaOeNext = 1'b0;
            endcase
        end

        case (w_nextState)
            S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK: w_busyNext = 1'b1;
            S_ADDR:  w_busyNext = r_busy;
            default: w_busyNext = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitCnt   <= 3'd0;
            r_byteDone <= 1'b0;
            r_shift    <= '0;
        end else if (w_start || w_stop) begin
            r_bitCnt   <= 3'd0;
            r_byteDone <= 1'b0;
        end else if (w_sclRise && w_shiftState) begin
            r_bitCnt <= r_bitCnt + 3'd1;
            r_shift  <= {r_shift[W-2:0], w_sda};
            if (r_bitCnt == 3'd7) r_byteDone <= 1'b1;
        end else if (w_sclFall) begin
            r_byteDone <= 1'b0;
        end
    end

    // An overflow in the same clock as clear_overflow keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sdaOe    <= 1'b0;
            r_busy     <= 1'b0;
            r_txShift  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_sdaOe <= w_sdaOeNext;
            r_busy  <= w_busyNext;
            if (w_txLoad) begin
                r_txShift <= {bus.tx_data[W-2:0], 1'b0};
            end else if (w_sclFall && (r_state == S_RD_DATA) && !r_byteDone) begin
                r_txShift <= {r_txShift[W-2:0], 1'b0};
            end
            if (w_setOvf) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // A pop in the same clock frees a slot, so a push into a full FIFO is accepted.
    assign w_count   = r_wrPtr - r_rdPtr;
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == C_FULL);
    assign w_pop     = bus.rx_rd & ~w_empty;
    assign w_canPush = ~w_full | w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr[M-1:0]] <= r_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    assign bus.sda_oe      = r_sdaOe;
    assign bus.busy        = r_busy;
    assign bus.tx_req      = w_txLoad;
    assign bus.rx_overflow = r_overflow;
    assign bus.rx_empty    = w_empty;
    assign bus.rx_full     = w_full;
    assign bus.rx_count    = w_count;
    assign bus.rx_data     = w_empty ? '0 : r_mem[r_rdPtr[M-1:0]];

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master on an open-drain SDA
// model, a table of address/write transactions and hand-written corner sequences.
module tb_i2c_target;

    localparam int Q = 8;

    logic clk = 1'b0;
    logic reset;
    logic tbScl;
    logic tbSda;
    int   total = 0;
    int   bad = 0;
    int   txReqCount = 0;
    int   oeCount = 0;

    always #5 clk = ~clk;

    i2c_target_if #(.W(8), .M(4)) bus ();

    assign bus.scl_in = tbScl;
    assign bus.sda_in = tbSda & ~bus.sda_oe;

    i2c_target #(.OWN_ADDR(7'h50), .W(8), .M(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always @(posedge clk) begin
        if (bus.tx_req) txReqCount <= txReqCount + 1;
        if (bus.sda_oe) oeCount <= oeCount + 1;
    end

    typedef struct {
        logic [7:0] addrByte;
        logic [7:0] dataByte;
        logic       expAck;
        logic [4:0] expCount;
        logic [7:0] expHead;
    } vec_t;

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic writeBit(input logic b);
        tbSda = b;
        waitClk(Q);
        tbScl = 1'b1;
        waitClk(2*Q);
        tbScl = 1'b0;
        waitClk(Q);
    endtask

    task automatic readBit(output logic b);
        tbSda = 1'b1;
        waitClk(Q);
        tbScl = 1'b1;
        waitClk(Q);
        b = bus.sda_in;
        waitClk(Q);
        tbScl = 1'b0;
        waitClk(Q);
    endtask

    task automatic startCond();
        tbSda = 1'b1;
        waitClk(Q);
        tbScl = 1'b1;
        waitClk(Q);
        tbSda = 1'b0;
        waitClk(Q);
        tbScl = 1'b0;
        waitClk(Q);
    endtask

    task automatic stopCond();
        tbSda = 1'b0;
        waitClk(Q);
        tbScl = 1'b1;
        waitClk(Q);
        tbSda = 1'b1;
        waitClk(Q);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic acked);
        logic lvl;
        for (int i = 7; i >= 0; i--) writeBit(b[i]);
        readBit(lvl);
        acked = ~lvl;
    endtask

    task automatic readByte(output logic [7:0] v, input logic [7:0] nextTx);
        logic bitVal;
        for (int i = 7; i >= 0; i--) begin
            readBit(bitVal);
            v[i] = bitVal;
            bus.tx_data = nextTx;
        end
    endtask

    task automatic popFifo();
        bus.rx_rd = 1'b1;
        waitClk(1);
        bus.rx_rd = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, output logic addrAck, output logic dataAck,
                                 output logic busyMid, output logic oeSeen);
        int oeStart;
        oeStart = oeCount;
        startCond();
        writeByte(v.addrByte, addrAck);
        busyMid = bus.busy;
        writeByte(v.dataByte, dataAck);
        stopCond();
        oeSeen = (oeCount != oeStart);
    endtask

    initial begin
        vec_t       vecs[4];
        logic       a0, a1, a2, busyMid, oeSeen;
        logic [7:0] rv;
        int         txStart;

        vecs[0] = '{addrByte: 8'hA2, dataByte: 8'h77, expAck: 1'b0, expCount: 5'd0, expHead: 8'h00};
        vecs[1] = '{addrByte: 8'hA0, dataByte: 8'h12, expAck: 1'b1, expCount: 5'd1, expHead: 8'h12};
        vecs[2] = '{addrByte: 8'h20, dataByte: 8'hFF, expAck: 1'b0, expCount: 5'd1, expHead: 8'h12};
        vecs[3] = '{addrByte: 8'hA0, dataByte: 8'hFE, expAck: 1'b1, expCount: 5'd2, expHead: 8'h12};

        tbScl = 1'b1;
        tbSda = 1'b1;
        bus.rx_rd = 1'b0;
        bus.clear_overflow = 1'b0;
        bus.tx_data = 8'h00;
        reset = 1'b1;
        waitClk(4);
        reset = 1'b0;
        waitClk(4);

        checkOutput("reset sda_oe", 32'(bus.sda_oe), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset tx_req", 32'(bus.tx_req), 32'd0);
        checkOutput("reset rx_empty", 32'(bus.rx_empty), 32'd1);
        checkOutput("reset rx_full", 32'(bus.rx_full), 32'd0);
        checkOutput("reset rx_overflow", 32'(bus.rx_overflow), 32'd0);
        checkOutput("reset rx_count", 32'(bus.rx_count), 32'd0);
        checkOutput("reset rx_data", 32'(bus.rx_data), 32'd0);

        $display("[TB] write 0x50+W, A5, 3C");
        startCond();
        writeByte(8'hA0, a0);
        writeByte(8'hA5, a1);
        writeByte(8'h3C, a2);
        stopCond();
        checkOutput("wr addr ack", 32'(a0), 32'd1);
        checkOutput("wr A5 ack", 32'(a1), 32'd1);
        checkOutput("wr 3C ack", 32'(a2), 32'd1);
        checkOutput("wr count", 32'(bus.rx_count), 32'd2);
        checkOutput("wr head A5", 32'(bus.rx_data), 32'hA5);
        checkOutput("wr busy after stop", 32'(bus.busy), 32'd0);
        popFifo();
        checkOutput("wr head 3C", 32'(bus.rx_data), 32'h3C);
        checkOutput("wr count after pop", 32'(bus.rx_count), 32'd1);
        popFifo();
        checkOutput("wr empty after drain", 32'(bus.rx_empty), 32'd1);

        $display("[TB] address table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], a0, a1, busyMid, oeSeen);
            checkOutput("tbl addr ack", 32'(a0), 32'(vecs[i].expAck));
            checkOutput("tbl data ack", 32'(a1), 32'(vecs[i].expAck));
            checkOutput("tbl busy mid", 32'(busyMid), 32'(vecs[i].expAck));
            checkOutput("tbl sda pulled", 32'(oeSeen), 32'(vecs[i].expAck));
            checkOutput("tbl count", 32'(bus.rx_count), 32'(vecs[i].expCount));
            checkOutput("tbl head", 32'(bus.rx_data), 32'(vecs[i].expHead));
            checkOutput("tbl busy after stop", 32'(bus.busy), 32'd0);
        end
        popFifo();
        checkOutput("tbl second entry", 32'(bus.rx_data), 32'hFE);
        popFifo();
        checkOutput("tbl drained", 32'(bus.rx_empty), 32'd1);

        $display("[TB] read 0x50+R");
        bus.tx_data = 8'h96;
        txStart = txReqCount;
        startCond();
        writeByte(8'hA1, a0);
        checkOutput("rd addr ack", 32'(a0), 32'd1);
        checkOutput("rd busy", 32'(bus.busy), 32'd1);
        readByte(rv, 8'h5A);
        checkOutput("rd byte 1", 32'(rv), 32'h96);
        writeBit(1'b0);
        readByte(rv, 8'h5A);
        checkOutput("rd byte 2", 32'(rv), 32'h5A);
        writeBit(1'b1);
        checkOutput("rd busy after nack", 32'(bus.busy), 32'd0);
        checkOutput("rd sda released", 32'(bus.sda_oe), 32'd0);
        checkOutput("rd tx_req pulses", 32'(txReqCount - txStart), 32'd2);
        stopCond();
        checkOutput("rd fifo untouched", 32'(bus.rx_empty), 32'd1);

        $display("[TB] overflow");
        startCond();
        writeByte(8'hA0, a0);
        checkOutput("ovf addr ack", 32'(a0), 32'd1);
        for (int i = 0; i < 17; i++) begin
            writeByte(8'(8'h10 + i), a1);
            checkOutput("ovf byte ack", 32'(a1), (i < 16) ? 32'd1 : 32'd0);
            if (i == 15) checkOutput("ovf flag before 17th", 32'(bus.rx_overflow), 32'd0);
        end
        stopCond();
        checkOutput("ovf full", 32'(bus.rx_full), 32'd1);
        checkOutput("ovf flag", 32'(bus.rx_overflow), 32'd1);
        checkOutput("ovf count", 32'(bus.rx_count), 32'd16);
        bus.clear_overflow = 1'b1;
        waitClk(1);
        bus.clear_overflow = 1'b0;
        checkOutput("ovf cleared", 32'(bus.rx_overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("ovf drain data", 32'(bus.rx_data), 32'(8'h10 + i));
            popFifo();
        end
        checkOutput("ovf drained", 32'(bus.rx_empty), 32'd1);

        $display("[TB] repeated start");
        bus.tx_data = 8'hC3;
        startCond();
        writeByte(8'hA0, a0);
        checkOutput("rs addr ack", 32'(a0), 32'd1);
        writeBit(1'b1);
        writeBit(1'b0);
        writeBit(1'b1);
        writeBit(1'b0);
        startCond();
        writeByte(8'hA1, a1);
        checkOutput("rs read addr ack", 32'(a1), 32'd1);
        readByte(rv, 8'hC3);
        checkOutput("rs read byte", 32'(rv), 32'hC3);
        writeBit(1'b1);
        stopCond();
        checkOutput("rs partial discarded", 32'(bus.rx_count), 32'd0);

        $display("[TB] reset during ACK");
        startCond();
        writeByte(8'hA0, a0);
        writeByte(8'h44, a1);
        stopCond();
        checkOutput("rst preload count", 32'(bus.rx_count), 32'd1);
        startCond();
        for (int i = 7; i >= 0; i--) writeBit(1'(8'hA0 >> i));
        checkOutput("rst driving ack", 32'(bus.sda_oe), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst sda_oe", 32'(bus.sda_oe), 32'd0);
        checkOutput("rst busy", 32'(bus.busy), 32'd0);
        checkOutput("rst tx_req", 32'(bus.tx_req), 32'd0);
        checkOutput("rst rx_empty", 32'(bus.rx_empty), 32'd1);
        checkOutput("rst rx_full", 32'(bus.rx_full), 32'd0);
        checkOutput("rst rx_overflow", 32'(bus.rx_overflow), 32'd0);
        checkOutput("rst rx_count", 32'(bus.rx_count), 32'd0);
        checkOutput("rst rx_data", 32'(bus.rx_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stopCond();
        startCond();
        writeByte(8'hA0, a0);
        writeByte(8'h99, a1);
        stopCond();
        checkOutput("post rst addr ack", 32'(a0), 32'd1);
        checkOutput("post rst data ack", 32'(a1), 32'd1);
        checkOutput("post rst count", 32'(bus.rx_count), 32'd1);
        checkOutput("post rst data", 32'(bus.rx_data), 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
